adc_capture_deadlock_reporter: RTL

Aggregates the 1-bit `block` outputs of the per-process deadlock monitors in the adc_capture dataflow region (the pair_iq flattening stage and its siblings). It debounces each flag with a per-monitor consecutive-stall counter and latches a sticky deadlock report when any flag stays high for STALL_CYCLES. It records which monitors tripped and raises a one-cycle interrupt pulse. The report is read by the capture control/status logic.

---
 rtl/adc_capture_deadlock_reporter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/adc_capture_deadlock_reporter.sv
// Debounces the adc_capture per-process deadlock monitor flags and latches a sticky report.
// irq is a one-cycle strobe that qualifies a new report; there is no ready, so readers must sample it the cycle it is high.
module adc_capture_deadlock_reporter #(
    parameter int N_MON        = 4,
    parameter int IDX_W        = 2,
    parameter int CNT_W        = 16,
    parameter int STALL_CYCLES = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_MON-1:0] mon_block,
    input  logic             enable,
    input  logic             clear,
    output logic             deadlock,
    output logic [N_MON-1:0] deadlock_src,
    output logic [IDX_W-1:0] first_idx,
    output logic             irq,
    output logic [CNT_W-1:0] max_stall,
    output logic [7:0]       event_count,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        TRIPPED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TRIP_AT = CNT_W'(STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt [N_MON];
    logic [N_MON-1:0]   trip;
    logic               trip_any;
    logic [IDX_W-1:0]   trip_idx;
    logic [CNT_W-1:0]   cnt_peak;
    logic               count_run;
    logic               track_max;
    logic               do_trip;
    logic               release_report;

    assign fsm_state = state;

    always_comb begin
        trip     = '0;
        trip_idx = '0;
        cnt_peak = '0;
        for (int i = 0; i < N_MON; i++) begin
            trip[i] = mon_block[i] && (cnt[i] == TRIP_AT);
            if (cnt[i] > cnt_peak) cnt_peak = cnt[i];
        end
        // Scan downwards so the lowest tripping index is the one left standing.
        for (int i = N_MON - 1; i >= 0; i--) begin
            if (trip[i]) trip_idx = IDX_W'(i);
        end
    end

    assign trip_any = |trip;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable) state_next = ARMED;
            end
            ARMED: begin
                if (clear)         state_next = enable ? ARMED : IDLE;
                else if (!enable)  state_next = IDLE;
                else if (trip_any) state_next = TRIPPED;
            end
            TRIPPED: begin
                if (clear) state_next = enable ? ARMED : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        count_run      = 1'b0;
        track_max      = 1'b0;
        do_trip        = 1'b0;
        release_report = 1'b0;
        case (state)
            ARMED: begin
                count_run = enable && !clear;
                track_max = !clear;
                do_trip   = enable && !clear && trip_any;
            end
            TRIPPED: begin
                // Keeps counting so max_stall still reflects how long the stall lasted.
                count_run      = !clear;
                track_max      = !clear;
                release_report = clear;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < N_MON; i++) begin
            if (reset || !count_run || !mon_block[i]) cnt[i] <= '0;
            else if (cnt[i] != CNT_MAX)               cnt[i] <= cnt[i] + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear)                      max_stall <= '0;
        else if (track_max && cnt_peak > max_stall) max_stall <= cnt_peak;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            deadlock     <= 1'b0;
            deadlock_src <= '0;
            first_idx    <= '0;
            irq          <= 1'b0;
            event_count  <= '0;
        end else begin
            irq <= do_trip;
            if (release_report) begin
                deadlock     <= 1'b0;
                deadlock_src <= '0;
                first_idx    <= '0;
            end else if (do_trip) begin
                deadlock     <= 1'b1;
                deadlock_src <= trip;
                first_idx    <= trip_idx;
                if (event_count != 8'hff) event_count <= event_count + 1'b1;
            end
        end
    end

endmodule
